rotor_inverse: RTL and testbench
================================

Name: rotor_inverse

Overview:
- Decryption-direction counterpart of the two-rotor encryption path.
- Takes a ciphertext letter code (1..26), passes it backward through rotor 2 and then rotor 1 using inverse wiring, and returns the plaintext code.
- Tracks rotor positions and steps them per accepted character, so it stays in lockstep with an encryptor that starts from the same setting.
- Sits between the ciphertext source and the plaintext sink, with valid/ready on both sides.

Parameters:
- INIT_P1, 3, rotor 1 position after reset (0..25)
- INIT_P2, 7, rotor 2 position after reset (0..25)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ciphertext code present
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  5  ciphertext code, legal 1..26
- load_en  in  1  overwrite rotor positions
- load_p1  in  5  new rotor 1 position (0..25)
- load_p2  in  5  new rotor 2 position (0..25)
- out_valid  out  1  plaintext available
- out_ready  in  1  sink accepts out_data
- out_data  out  5  plaintext code 1..26, 0 on error
- out_err  out  1  accompanying input was illegal
- pos_p1  out  5  current rotor 1 position
- pos_p2  out  5  current rotor 2 position

Behaviour:
- Wiring (index 1..26):
  - R1 = 10,7,4,17,15,24,21,19,3,1,13,9,6,18,22,20,16,14,5,23,11,2,12,26,25,8
  - R2 = 14,20,26,16,19,6,2,15,11,13,23,18,3,10,4,9,22,12,1,5,25,21,24,8,7,17
  - R1inv and R2inv are constant inverse tables.
- Encryptor definition: y = R2[sh(R1[sh(x,p1)],p2)], where sh(v,p) = ((v-1+p) mod 26)+1.
- Decryption:
  - m = ((R2inv[y]-1-p2) mod 26)+1
  - x = ((R1inv[m]-1-p1) mod 26)+1
  - All mod-26 arithmetic is done in at least 6 bits; no value outside 1..26 is ever produced for legal input.
- Accept: a transfer occurs when in_valid && in_ready. The p1/p2 values used are those current in the accept cycle; they are captured with the data.
- Pipeline:
  - 2 stages. S1 = R2 inverse and p2 subtraction; S2 = R1 inverse and p1 subtraction.
  - out_valid is asserted 2 cycles after accept when there is no stall.
  - Full throughput: 1 character/cycle.
- Stall:
  - Each stage advances when its downstream is empty or being consumed.
  - in_ready = !S1_full || S1_advances.
  - out_data, out_err and out_valid are held stable while out_valid && !out_ready.
- Stepping:
  - On each legal accept, p1 <= (p1+1) mod 26 (25 wraps to 0).
  - p2 does not step (see Optional Feature).
- Illegal input (0 or 27..31):
  - Still accepted and travels the pipeline.
  - Emerges with out_data=0 and out_err=1.
  - Positions do not step.
- Load:
  - With load_en=1, p1/p2 <= load values mod 26 and in_ready=0 that cycle.
  - Load takes priority over accept.
  - Characters already in flight keep their captured positions.
- Reset:
  - p1=INIT_P1, p2=INIT_P2.
  - Pipeline emptied; out_valid=0, out_data=0, out_err=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-stream discards in-flight characters with no output.

Optional Feature:
- Macro: ROTOR_INV_ODOMETER_EN.
- Defined: when a legal accept wraps p1 from 25 to 0, p2 <= (p2+1) mod 26 in the same cycle (odometer carry). This must match an encryptor built with the same carry.
- Undefined: p2 changes only on reset or load.

Test Plan:
- Reset, then feed 8 followed by 21 back-to-back with out_ready=1 -> out_data 1 then 1 (positions p1=3 then 4), out_valid asserted 2 cycles after each accept; pos_p1 ends at 5.
- Random plaintext stream through a reference encryptor model, decrypted with the same initial setting -> every out_data equals the original plaintext, over 100+ characters crossing the p1 wrap.
- Load p1=25, p2=0, then feed 3 legal characters -> pos_p1 goes 25, 0, 1; pos_p2 stays 0 (macro undefined) or becomes 1 after the 1st accept (macro defined).
- Feed 0 and then 31 -> out_data=0 and out_err=1 for both; pos_p1 unchanged.
- Hold out_ready=0 for 5 cycles with 3 characters offered -> in_ready falls once both stages are full, out_data is stable, no character is lost or duplicated after release.
- Assert rst with 2 characters in flight -> no out_valid afterwards; pos_p1=3, pos_p2=7.

Source files
------------

// File: rtl/rotor_inverse.sv
// rotor_inverse: two-stage decryption pipeline (R2 inverse, then R1 inverse) with rotor stepping.
// Optional macro ROTOR_INV_ODOMETER_EN: a p1 wrap from 25 to 0 carries into p2.
module rotor_inverse #(
  parameter int INIT_P1 = 3,
  parameter int INIT_P2 = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_data,
  input  logic       load_en,
  input  logic [4:0] load_p1,
  input  logic [4:0] load_p2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_data,
  output logic       out_err,
  output logic [4:0] pos_p1,
  output logic [4:0] pos_p2
);
  localparam int DATA_W = 5;

  function automatic logic [DATA_W-1:0] r1_inv(input logic [DATA_W-1:0] v);
    case (v)
      5'd1:    r1_inv = 5'd10;
      5'd2:    r1_inv = 5'd22;
      5'd3:    r1_inv = 5'd9;
      5'd4:    r1_inv = 5'd3;
      5'd5:    r1_inv = 5'd19;
      5'd6:    r1_inv = 5'd13;
      5'd7:    r1_inv = 5'd2;
      5'd8:    r1_inv = 5'd26;
      5'd9:    r1_inv = 5'd12;
      5'd10:   r1_inv = 5'd1;
      5'd11:   r1_inv = 5'd21;
      5'd12:   r1_inv = 5'd23;
      5'd13:   r1_inv = 5'd11;
      5'd14:   r1_inv = 5'd18;
      5'd15:   r1_inv = 5'd5;
      5'd16:   r1_inv = 5'd17;
      5'd17:   r1_inv = 5'd4;
      5'd18:   r1_inv = 5'd14;
      5'd19:   r1_inv = 5'd8;
      5'd20:   r1_inv = 5'd16;
      5'd21:   r1_inv = 5'd7;
      5'd22:   r1_inv = 5'd15;
      5'd23:   r1_inv = 5'd20;
      5'd24:   r1_inv = 5'd6;
      5'd25:   r1_inv = 5'd25;
      5'd26:   r1_inv = 5'd24;
      default: r1_inv = 5'd1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] r2_inv(input logic [DATA_W-1:0] v);
    case (v)
      5'd1:    r2_inv = 5'd19;
      5'd2:    r2_inv = 5'd7;
      5'd3:    r2_inv = 5'd13;
      5'd4:    r2_inv = 5'd15;
      5'd5:    r2_inv = 5'd20;
      5'd6:    r2_inv = 5'd6;
      5'd7:    r2_inv = 5'd25;
      5'd8:    r2_inv = 5'd24;
      5'd9:    r2_inv = 5'd16;
      5'd10:   r2_inv = 5'd14;
      5'd11:   r2_inv = 5'd9;
      5'd12:   r2_inv = 5'd18;
      5'd13:   r2_inv = 5'd10;
      5'd14:   r2_inv = 5'd1;
      5'd15:   r2_inv = 5'd8;
      5'd16:   r2_inv = 5'd4;
      5'd17:   r2_inv = 5'd26;
      5'd18:   r2_inv = 5'd12;
      5'd19:   r2_inv = 5'd5;
      5'd20:   r2_inv = 5'd2;
      5'd21:   r2_inv = 5'd22;
      5'd22:   r2_inv = 5'd17;
      5'd23:   r2_inv = 5'd11;
      5'd24:   r2_inv = 5'd23;
      5'd25:   r2_inv = 5'd21;
      5'd26:   r2_inv = 5'd3;
      default: r2_inv = 5'd1;
    endcase
  endfunction

  // Letter a (1..26) shifted back by p (0..25), wrapped into 1..26.
  function automatic logic [DATA_W-1:0] sub_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] p);
    logic signed [6:0] d;
    d = $signed({2'b00, a}) - 7'sd1 - $signed({2'b00, p});
    if (d < 7'sd0) d = d + 7'sd26;
    sub_wrap = d[4:0] + 5'd1;
  endfunction

  function automatic logic [DATA_W-1:0] mod26(input logic [DATA_W-1:0] v);
    mod26 = (v >= 5'd26) ? v - 5'd26 : v;
  endfunction

  function automatic logic [DATA_W-1:0] step26(input logic [DATA_W-1:0] v);
    step26 = (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  logic [DATA_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic              vld_p1_q, vld_p1_d;
  logic              err_p1_q, err_p1_d;
  logic [DATA_W-1:0] m_p1_q, m_p1_d;
  logic [DATA_W-1:0] cap_p1_q, cap_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic              err_p2_q, err_p2_d;
  logic [DATA_W-1:0] x_p2_q, x_p2_d;
  logic              legal, accept, adv_p1, adv_p2;

  // Handshake: output register loads when empty or drained; S1 moves when it can hand off.
  always_comb begin
    legal    = (in_data >= 5'd1) && (in_data <= 5'd26);
    adv_p2   = !vld_p2_q || out_ready;
    adv_p1   = vld_p1_q && adv_p2;
    in_ready = !load_en && (!vld_p1_q || adv_p1);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    p1_d = p1_q;
    p2_d = p2_q;
    if (load_en) begin
      p1_d = mod26(load_p1);
      p2_d = mod26(load_p2);
    end else if (accept && legal) begin
      p1_d = step26(p1_q);
`ifdef ROTOR_INV_ODOMETER_EN
      if (p1_q == 5'd25) p2_d = step26(p2_q);
`endif
    end
  end

  // Stage p0 -> p1: R2 inverse and p2 removal; p1 is captured for the next stage.
  always_comb begin
    vld_p1_d = vld_p1_q;
    err_p1_d = err_p1_q;
    m_p1_d   = m_p1_q;
    cap_p1_d = cap_p1_q;
    if (accept) begin
      vld_p1_d = 1'b1;
      err_p1_d = !legal;
      m_p1_d   = sub_wrap(r2_inv(in_data), p2_q);
      cap_p1_d = p1_q;
    end else if (adv_p1) begin
      vld_p1_d = 1'b0;
    end
  end

  // Stage p1 -> p2: R1 inverse and p1 removal; illegal characters emerge as 0.
  always_comb begin
    vld_p2_d = vld_p2_q;
    err_p2_d = err_p2_q;
    x_p2_d   = x_p2_q;
    if (adv_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        err_p2_d = err_p1_q;
        x_p2_d   = err_p1_q ? 5'd0 : sub_wrap(r1_inv(m_p1_q), cap_p1_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q     <= INIT_P1[4:0];
      p2_q     <= INIT_P2[4:0];
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      err_p2_q <= 1'b0;
      x_p2_q   <= 5'd0;
    end else begin
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      err_p2_q <= err_p2_d;
      x_p2_q   <= x_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    err_p1_q <= err_p1_d;
    m_p1_q   <= m_p1_d;
    cap_p1_q <= cap_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_data  = x_p2_q;
  assign out_err   = err_p2_q;
  assign pos_p1    = p1_q;
  assign pos_p2    = p2_q;

endmodule

// File: tb/tb_rotor_inverse.sv
// tb_rotor_inverse: directed vectors plus a randomized stream checked against a forward-encryptor model.
module tb_rotor_inverse;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, load_en, out_valid, out_ready, out_err;
  logic [4:0] in_data, load_p1, load_p2, out_data, pos_p1, pos_p2;

  always #5 clk = ~clk;

  rotor_inverse #(.INIT_P1(3), .INIT_P2(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .load_en(load_en), .load_p1(load_p1), .load_p2(load_p2), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .pos_p1(pos_p1), .pos_p2(pos_p2)
  );

`ifdef ROTOR_INV_ODOMETER_EN
  localparam bit ODO = 1'b1;
`else
  localparam bit ODO = 1'b0;
`endif

  int r1 [1:26] = '{10,7,4,17,15,24,21,19,3,1,13,9,6,18,22,20,16,14,5,23,11,2,12,26,25,8};
  int r2 [1:26] = '{14,20,26,16,19,6,2,15,11,13,23,18,3,10,4,9,22,12,1,5,25,21,24,8,7,17};

  int n_checks = 0;
  int n_fail = 0;
  int mp1, mp2;
  int pend_x, pend_y, pend_e;

  typedef struct { int lp1; int lp2; int din; int exp_d; int exp_e; } vec_t;
  typedef struct { int d; int e; } exp_t;
  vec_t vecs[9];
  exp_t expq[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sh(input int v, input int p);
    return ((v - 1 + p) % 26) + 1;
  endfunction

  function automatic int enc(input int x, input int p1, input int p2);
    return r2[sh(r1[sh(x, p1)], p2)];
  endfunction

  // Decrypt by brute force: the plaintext is whichever letter encrypts to y.
  function automatic int dec(input int y, input int p1, input int p2);
    for (int x = 1; x <= 26; x++) if (enc(x, p1, p2) == y) return x;
    return 0;
  endfunction

  function automatic void model_step();
    if (mp1 == 25) begin
      mp1 = 0;
      if (ODO) mp2 = (mp2 + 1) % 26;
    end else begin
      mp1 = mp1 + 1;
    end
  endfunction

  task automatic new_pending();
    if ($urandom_range(0, 15) == 0) begin
      pend_y = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(27, 31));
      pend_x = 0;
      pend_e = 1;
    end else begin
      pend_x = $urandom_range(1, 26);
      pend_y = enc(pend_x, mp1, mp2);
      pend_e = 0;
    end
  endtask

  initial begin
    int lat, na, got, held, saw_low, prev_stall, prev_d, prev_e, sent;
    int ys[3];
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; in_data = 5'd0; load_en = 1'b0;
    load_p1 = 5'd0; load_p2 = 5'd0; out_ready = 1'b1;
    vecs[0] = '{3, 7, 8, 1, 0};
    vecs[1] = '{4, 7, 21, 1, 0};
    vecs[2] = '{0, 0, 1, 8, 0};
    vecs[3] = '{25, 0, 14, 11, 0};
    vecs[4] = '{29, 7, 8, 1, 0};
    vecs[5] = '{26, 30, 10, 1, 0};
    vecs[6] = '{5, 5, 0, 0, 1};
    vecs[7] = '{5, 5, 31, 0, 1};
    vecs[8] = '{5, 5, 27, 0, 1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_pos_p1", int'(pos_p1), 3);
    check("rst_pos_p2", int'(pos_p2), 7);
    check("rst_in_ready", int'(in_ready), 1);

    // Back-to-back 8, 21 from reset positions.
    @(negedge clk); in_valid = 1'b1; in_data = 5'd8;
    @(negedge clk); in_data = 5'd21;
    #1 check("b2b_latency_early", int'(out_valid), 0);
    @(negedge clk); in_valid = 1'b0;
    #1 check("b2b_first_valid", int'(out_valid), 1);
    check("b2b_first_data", int'(out_data), 1);
    @(negedge clk);
    check("b2b_second_valid", int'(out_valid), 1);
    check("b2b_second_data", int'(out_data), 1);
    @(negedge clk);
    check("b2b_drained", int'(out_valid), 0);
    check("b2b_pos_p1", int'(pos_p1), 5);
    check("b2b_pos_p2", int'(pos_p2), 7);

    // Table: load positions, send one character, compare result and latency.
    foreach (vecs[i]) begin
      @(negedge clk);
      load_en = 1'b1; load_p1 = 5'(vecs[i].lp1); load_p2 = 5'(vecs[i].lp2);
      in_valid = 1'b1; in_data = 5'(vecs[i].din);
      #1 check("load_blocks_in_ready", int'(in_ready), 0);
      @(negedge clk); load_en = 1'b0;
      mp1 = vecs[i].lp1 % 26; mp2 = vecs[i].lp2 % 26;
      check("vec_load_p1", int'(pos_p1), mp1);
      check("vec_load_p2", int'(pos_p2), mp2);
      #1 check("vec_in_ready", int'(in_ready), 1);
      @(negedge clk); in_valid = 1'b0; lat = 1;
      while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
      check("vec_latency", lat, 2);
      check("vec_data", int'(out_data), vecs[i].exp_d);
      check("vec_err", int'(out_err), vecs[i].exp_e);
      if (vecs[i].exp_e == 0) model_step();
      check("vec_pos_p1", int'(pos_p1), mp1);
      check("vec_pos_p2", int'(pos_p2), mp2);
      @(negedge clk);
    end

    // Load 25/0 then three legal characters: p1 wraps, p2 carries only with the odometer.
    @(negedge clk); load_en = 1'b1; load_p1 = 5'd25; load_p2 = 5'd0;
    @(negedge clk); load_en = 1'b0;
    check("wrap_load_p1", int'(pos_p1), 25);
    check("wrap_load_p2", int'(pos_p2), 0);
    mp1 = 25; mp2 = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 5'($urandom_range(1, 26));
      #1 check("wrap_in_ready", int'(in_ready), 1);
      @(negedge clk);
      model_step();
      check("wrap_pos_p1", int'(pos_p1), k);
      check("wrap_pos_p2", int'(pos_p2), ODO ? 1 : 0);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Illegal codes 0 and 31: flagged, no stepping.
    in_valid = 1'b1; in_data = 5'd0;
    @(negedge clk); in_data = 5'd31;
    @(negedge clk); in_valid = 1'b0;
    check("illegal0_valid", int'(out_valid), 1);
    check("illegal0_data", int'(out_data), 0);
    check("illegal0_err", int'(out_err), 1);
    @(negedge clk);
    check("illegal31_valid", int'(out_valid), 1);
    check("illegal31_data", int'(out_data), 0);
    check("illegal31_err", int'(out_err), 1);
    check("illegal_pos_p1", int'(pos_p1), mp1);
    check("illegal_pos_p2", int'(pos_p2), mp2);
    repeat (2) @(negedge clk);

    // Stall: sink blocked for 5 cycles while 3 characters are offered.
    ys[0] = 5; ys[1] = 17; ys[2] = 23;
    expq.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 5'(ys[0]);
    na = 0; saw_low = 0; held = -1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (in_ready) begin
        expq.push_back('{dec(ys[na], mp1, mp2), 0}); model_step(); na++;
      end else saw_low = 1;
      @(negedge clk);
      if (na < 3) in_data = 5'(ys[na]); else in_valid = 1'b0;
      if (out_valid) begin
        if (held < 0) held = int'(out_data);
        else check("stall_hold_data", int'(out_data), held);
      end
    end
    check("stall_accepted", na, 2);
    check("stall_in_ready_fell", saw_low, 1);
    check("stall_out_valid", int'(out_valid), 1);
    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      #1;
      if (in_valid && in_ready) begin
        expq.push_back('{dec(ys[na], mp1, mp2), 0}); model_step(); na++;
      end
      if (out_valid) begin
        if (expq.size() == 0) check("stall_unexpected_output", 1, 0);
        else begin e = expq.pop_front(); check("stall_data", int'(out_data), e.d); end
        got++;
      end
      @(negedge clk);
      if (na < 3) begin in_valid = 1'b1; in_data = 5'(ys[na]); end else in_valid = 1'b0;
    end
    check("stall_delivered", got, 3);
    for (int c = 0; c < 4; c++) begin
      #1 check("stall_no_duplicate", int'(out_valid), 0);
      @(negedge clk);
    end

    // Random stream with random backpressure, crossing the p1 wrap several times.
    load_en = 1'b1; load_p1 = 5'd20; load_p2 = 5'd11;
    @(negedge clk); load_en = 1'b0;
    mp1 = 20; mp2 = 11;
    expq.delete();
    new_pending();
    sent = 0; got = 0; prev_stall = 0; prev_d = 0; prev_e = 0;
    for (int c = 0; c < 5000 && got < 130; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 130) begin in_valid = ($urandom_range(0, 4) != 0); in_data = 5'(pend_y); end
      else in_valid = 1'b0;
      #1;
      if (prev_stall != 0) begin
        check("rand_hold_valid", int'(out_valid), 1);
        check("rand_hold_data", int'(out_data), prev_d);
        check("rand_hold_err", int'(out_err), prev_e);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("rand_unexpected_output", 1, 0);
        else begin
          e = expq.pop_front();
          check("rand_data", int'(out_data), e.d);
          check("rand_err", int'(out_err), e.e);
        end
        got++;
      end
      prev_stall = int'(out_valid && !out_ready);
      prev_d = int'(out_data); prev_e = int'(out_err);
      if (in_valid && in_ready) begin
        expq.push_back('{pend_x, pend_e});
        if (pend_e == 0) model_step();
        sent++;
        new_pending();
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand_delivered", got, 130);
    check("rand_pos_p1", int'(pos_p1), mp1);
    check("rand_pos_p2", int'(pos_p2), mp2);
    repeat (3) @(negedge clk);

    // Reset with two characters in flight: nothing may emerge afterwards.
    in_valid = 1'b1; in_data = 5'd4;
    @(negedge clk); in_data = 5'd9; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_out_err", int'(out_err), 0);
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("midrst_no_output", int'(out_valid), 0);
    end
    check("midrst_pos_p1", int'(pos_p1), 3);
    check("midrst_pos_p2", int'(pos_p2), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
